// File: rtl/osd_mam_if_arbiter.sv
// Two-requester arbiter in front of the MAM Wishbone bridge: one requester owns the
// req/write/read channels for a whole transaction; ties are broken round-robin.
module osd_mam_if_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic                    req0_rw,
    input  logic                    req0_burst,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [13:0]             req0_beats,
    input  logic                    write0_valid,
    output logic                    write0_ready,
    input  logic [DATA_WIDTH-1:0]   write0_data,
    input  logic [DATA_WIDTH/8-1:0] write0_strb,
    output logic                    read0_valid,
    input  logic                    read0_ready,
    output logic [DATA_WIDTH-1:0]   read0_data,

    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic                    req1_rw,
    input  logic                    req1_burst,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic [13:0]             req1_beats,
    input  logic                    write1_valid,
    output logic                    write1_ready,
    input  logic [DATA_WIDTH-1:0]   write1_data,
    input  logic [DATA_WIDTH/8-1:0] write1_strb,
    output logic                    read1_valid,
    input  logic                    read1_ready,
    output logic [DATA_WIDTH-1:0]   read1_data,

    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_rw,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic                    req_burst,
    output logic [13:0]             req_beats,
    output logic                    write_valid,
    input  logic                    write_ready,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH/8-1:0] write_strb,
    input  logic                    read_valid,
    output logic                    read_ready,
    input  logic [DATA_WIDTH-1:0]   read_data,

    output logic [1:0]              grant_o
);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, READ} state_t;

    state_t      state, state_nxt;
    logic        gnt, gnt_nxt;
    logic        last, last_nxt;
    logic        rw, rw_nxt;
    logic [13:0] cnt, cnt_nxt;

    logic        g_req_valid, g_rw, g_burst;
    logic [13:0] g_beats;
    logic        g_write_valid, g_read_ready;
    logic        beat_hs;

    assign g_req_valid   = gnt ? req1_valid   : req0_valid;
    assign g_rw          = gnt ? req1_rw      : req0_rw;
    assign g_burst       = gnt ? req1_burst   : req0_burst;
    assign g_beats       = gnt ? req1_beats   : req0_beats;
    assign g_write_valid = gnt ? write1_valid : write0_valid;
    assign g_read_ready  = gnt ? read1_ready  : read0_ready;

    // Request and write payloads follow the grant at all times; only the valids are gated.
    assign req_rw     = g_rw;
    assign req_burst  = g_burst;
    assign req_beats  = g_beats;
    assign req_addr   = gnt ? req1_addr   : req0_addr;
    assign write_data = gnt ? write1_data : write0_data;
    assign write_strb = gnt ? write1_strb : write0_strb;
    assign read0_data = read_data;
    assign read1_data = read_data;

    assign grant_o = (state == IDLE) ? 2'b00 : (gnt ? 2'b10 : 2'b01);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            rw    <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            rw    <= rw_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        last_nxt     = last;
        rw_nxt       = rw;
        cnt_nxt      = cnt;
        req_valid    = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        write_valid  = 1'b0;
        write0_ready = 1'b0;
        write1_ready = 1'b0;
        read_ready   = 1'b0;
        read0_valid  = 1'b0;
        read1_valid  = 1'b0;
        beat_hs      = 1'b0;

        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    gnt_nxt   = (req0_valid && req1_valid) ? !last : req1_valid;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                req_valid  = g_req_valid;
                req0_ready = !gnt && req_ready;
                req1_ready = gnt && req_ready;
                if (req_valid && req_ready) begin
                    rw_nxt    = g_rw;
                    // Single transfers ignore the beats field; a zero-length burst is one beat.
                    cnt_nxt   = (g_burst && g_beats != '0) ? g_beats : 14'd1;
                    state_nxt = g_rw ? WRITE : READ;
                end
            end
            WRITE, READ: begin
                if (rw) begin
                    write_valid  = g_write_valid;
                    write0_ready = !gnt && write_ready;
                    write1_ready = gnt && write_ready;
                    beat_hs      = write_valid && write_ready;
                end else begin
                    read_ready  = g_read_ready;
                    read0_valid = !gnt && read_valid;
                    read1_valid = gnt && read_valid;
                    beat_hs     = read_valid && read_ready;
                end
                if (beat_hs && cnt != '0) begin
                    cnt_nxt = cnt - 14'd1;
                    if (cnt == 14'd1) begin
                        state_nxt = IDLE;
                        last_nxt  = gnt;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
